// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame shape, FSM states and
// the default bit period for a 50 MHz clock at 115200 baud.
package uart_pkg;

    localparam int CLK_HZ            = 50_000_000;
    localparam int BAUD              = 115_200;
    localparam int CLKS_PER_BIT_DFLT = CLK_HZ / BAUD;
    localparam int DATA_BITS         = 8;
    localparam int STOP_BITS         = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous DEPTH x 8 FIFO with count-based flags and first-word-fall-through
// read data. A push while full is ignored even if a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accept/pop qualification and next occupancy.
    always_comb begin
        full_o    = (count_q == FULL_CNT);
        empty_o   = (count_q == {CW{1'b0}});
        push_ok_s = push_i & ~full_o;
        pop_ok_s  = pop_i & ~empty_o;
        count_d   = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        rdata_o   = mem_q[rd_ptr_q];
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes strobed in are queued in byte_fifo and
// shifted out LSB first, back-to-back while the queue holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       tx,
    output logic       active,
    output logic       overflow
);

    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int BITW = $clog2(DATA_BITS);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_BITS - 1);
    localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

    tx_state_e       state_q;
    logic [BW-1:0]   baud_q;
    logic [BITW-1:0] bit_q;
    logic [7:0]      shift_q;
    logic            line_q;
    logic            tx_q;
    logic            busy_q;
    logic            active_q;
    logic            overflow_q;

    logic [7:0]      fifo_rdata_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            baud_end_s;
    logic            pop_s;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (txStart),
        .wdata_i (txData),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // A new frame is loaded from idle, or straight from the end of a stop bit.
    always_comb begin
        baud_end_s = (baud_q == BAUD_LAST);
        if (fifo_empty_s) begin
            pop_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: pop_s = 1'b1;
                ST_STOP: pop_s = baud_end_s && (bit_q == STOP_LAST);
                default: pop_s = 1'b0;
            endcase
        end
    end

    // Frame FSM with baud/bit counters and shifter; line_q is the bit level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= {BITW{1'b0}};
            shift_q <= 8'h00;
            line_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    line_q <= ~pop_s;
                    if (pop_s) begin
                        shift_q <= fifo_rdata_s;
                        baud_q  <= {BW{1'b0}};
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_q  <= {BW{1'b0}};
                        bit_q   <= {BITW{1'b0}};
                        line_q  <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_q <= {BW{1'b0}};
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= {BITW{1'b0}};
                            line_q  <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + BITW'(1);
                            shift_q <= {1'b0, shift_q[7:1]};
                            line_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_q <= {BW{1'b0}};
                        if (bit_q != STOP_LAST) begin
                            bit_q <= bit_q + BITW'(1);
                        end else if (pop_s) begin
                            bit_q   <= {BITW{1'b0}};
                            shift_q <= fifo_rdata_s;
                            line_q  <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            bit_q   <= {BITW{1'b0}};
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

    // Registered outputs; tx is retimed from line_q so the pin sees only a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tx_q       <= line_q;
            busy_q     <= fifo_full_s;
            active_q   <= (state_q != ST_IDLE) || !fifo_empty_s;
            overflow_q <= overflow_q | (txStart & fifo_full_s);
        end
    end

    assign tx       = tx_q;
    assign txBusy   = busy_q;
    assign active   = active_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at 4 clocks per bit: stimulus queues the
// expected bytes, an independent line monitor decodes frames and compares.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txBusy;
    logic       tx;
    logic       active;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_ignore = 1'b0;
    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .txStart  (txStart),
        .txData   (txData),
        .txBusy   (txBusy),
        .tx       (tx),
        .active   (active),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit expect_tx);
        @(negedge clk);
        txStart = 1'b1;
        txData  = b;
        if (expect_tx) sb.push_back(b);
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < budget), 32'd1);
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic check_gaps(input string name, input int frames);
        int bad = 0;
        check({name, "_frames"}, 32'(starts.size()), 32'(frames));
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 10 * CPB) bad++;
        end
        check({name, "_gaps"}, 32'(bad), 32'd0);
    endtask

    // Line monitor: samples mid-bit, pops the scoreboard at each decoded frame.
    initial begin
        logic [7:0] data;
        logic       sbit;
        logic       stopb;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset_n && tx == 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                sbit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    data[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stopb = tx;
                if (!mon_ignore) begin
                    starts.push_back(t0);
                    check("start_bit", 32'(sbit), 32'd0);
                    check("stop_bit", 32'(stopb), 32'd1);
                    check("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) check("rx_byte", 32'(data), 32'(sb.pop_front()));
                end
                repeat (CPB - 3) @(negedge clk);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] got_w;
        logic [41:0] exp_w;
        logic        lv [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        act41;
        logic        act42;
        bit          low_seen;
        bit          busy_seen;

        // Reset state
        idle(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(txBusy), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check("idle_tx_high", 32'(low_seen), 32'd0);

        // Single byte 0x0A: exact line waveform and latency
        send(8'h0A, 1'b1);
        act41 = 1'b0;
        act42 = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            got_w[k-1] = tx;
            exp_w[k-1] = (k == 1 || k == 42) ? 1'b1 : lv[(k - 2) / CPB];
            if (k == 41) act41 = active;
            if (k == 42) act42 = active;
        end
        check("single_wave", 32'(got_w[31:0]), 32'(exp_w[31:0]));
        check("single_wave_hi", 32'(got_w[41:32]), 32'(exp_w[41:32]));
        check("active_in_stop", 32'(act41), 32'd1);
        check("active_after_stop", 32'(act42), 32'd0);
        wait_drain(200);

        // Burst of 16 bytes every other cycle
        starts.delete();
        busy_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1);
            if (txBusy) busy_seen = 1'b1;
        end
        check("burst_busy", 32'(busy_seen), 32'd0);
        check("burst_overflow", 32'(overflow), 32'd0);
        wait_drain(1000);
        check_gaps("burst", 16);

        // Push and pop on the same edge at the end of a stop bit
        starts.delete();
        send(8'hA5, 1'b1);
        idle(3);
        send(8'h3C, 1'b1);
        idle(34);
        send(8'hE1, 1'b1);
        wait_drain(400);
        check_gaps("pushpop", 3);

        // Fill to overflow with consecutive strobes
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 16) check("busy_before_full", 32'(txBusy), 32'd0);
            txStart = 1'b1;
            txData  = 8'h20 + 8'(i);
            if (i < 17) sb.push_back(8'h20 + 8'(i));
        end
        @(negedge clk);
        txStart = 1'b0;
        check("full_busy", 32'(txBusy), 32'd1);
        check("full_overflow", 32'(overflow), 32'd1);
        wait_drain(3000);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("busy_cleared", 32'(txBusy), 32'd0);
        do_reset();
        check("overflow_reset", 32'(overflow), 32'd0);

        // Reset during data bit 3 of 0xC3 with a second byte queued
        mon_ignore = 1'b1;
        send(8'hC3, 1'b0);
        send(8'h99, 1'b0);
        idle(18);
        reset_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_active", 32'(active), 32'd0);
        idle(3);
        reset_n = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || active !== 1'b0) low_seen = 1'b1;
        end
        check("midrst_fifo_empty", 32'(low_seen), 32'd0);
        mon_ignore = 1'b0;
        starts.delete();
        send(8'h55, 1'b1);
        wait_drain(200);
        check("post_rst_frames", 32'(starts.size()), 32'd1);
        check("post_rst_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
